// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS-subset controllers: opcodes, funct codes,
// FSM states, datapath select encodings, instruction classes and control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 4;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned COUNT_W  = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [SEL_W-1:0] SEL_PC_PLUS4  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_PC_BRANCH = 2'd1;
  localparam logic [SEL_W-1:0] SEL_PC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_PC_RS     = 2'd3;

  localparam logic [SEL_W-1:0] SEL_RES_ALU   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_RES_DMEM  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_RES_PC4   = 2'd2;

  localparam logic [SEL_W-1:0] SEL_WA_RT     = 2'd0;
  localparam logic [SEL_W-1:0] SEL_WA_RD     = 2'd1;
  localparam logic [SEL_W-1:0] SEL_WA_R31    = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE    = 4'd0,
    CL_RTYPE   = 4'd1,
    CL_JR      = 4'd2,
    CL_LW      = 4'd3,
    CL_SW      = 4'd4,
    CL_BEQ     = 4'd5,
    CL_ADDI    = 4'd6,
    CL_J       = 4'd7,
    CL_JAL     = 4'd8,
    CL_ILLEGAL = 4'd9
  } iclass_e;

  typedef struct packed {
    logic              ir_we;
    logic              pc_we;
    logic              rf_we;
    logic [SEL_W-1:0]  sel_wa;
    logic              sel_alu_b;
    logic [SEL_W-1:0]  sel_result;
    logic [SEL_W-1:0]  sel_pc;
    logic [ALU_W-1:0]  alu_ctrl;
    logic              dmem_re;
    logic              dmem_we;
  } ctrl_t;

  // Map opcode plus the funct decoder's verdict onto an instruction class.
  function automatic iclass_e classify(input logic [OP_W-1:0] op,
                                       input logic            fn_legal,
                                       input logic            fn_is_jr);
    iclass_e cl;
    cl = CL_ILLEGAL;
    case (op)
      OP_RTYPE: if (fn_legal) cl = fn_is_jr ? CL_JR : CL_RTYPE;
      OP_LW:    cl = CL_LW;
      OP_SW:    cl = CL_SW;
      OP_BEQ:   cl = CL_BEQ;
      OP_ADDI:  cl = CL_ADDI;
      OP_J:     cl = CL_J;
      OP_JAL:   cl = CL_JAL;
      default:  cl = CL_ILLEGAL;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: ALU control, jr detection and a legality flag.
// Purely combinational so both the multi-cycle and single-cycle controllers can share it.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               is_jr,
  output logic               legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    is_jr    = 1'b0;
    legal    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_JR:   is_jr    = 1'b1;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset main controller (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional cycle/instret counters are built when MC_CONTROL_PERF_COUNTERS_EN is defined.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter logic [STATE_W-1:0] RESET_STATE = 3'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [SEL_W-1:0]     sel_wa,
  output logic                 sel_alu_b,
  output logic [SEL_W-1:0]     sel_result,
  output logic [SEL_W-1:0]     sel_pc,
  output logic [ALU_W-1:0]     alu_ctrl,
  output logic                 dmem_re,
  output logic                 dmem_we,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state,
  output logic [COUNT_W-1:0]   cycle_count,
  output logic [COUNT_W-1:0]   instret_count
);

  state_e           state_q, state_d;
  iclass_e          class_q, class_d;
  logic [ALU_W-1:0] alu_q, alu_d;
  logic             illegal_q, illegal_d;

  logic [ALU_W-1:0] fn_alu;
  logic             fn_is_jr;
  logic             fn_legal;
  iclass_e          dec_class;
  ctrl_t            ctrl_c;

  mc_alu_decoder u_alu_dec (
    .funct    (funct),
    .alu_ctrl (fn_alu),
    .is_jr    (fn_is_jr),
    .legal    (fn_legal)
  );

  assign dec_class = classify(opcode, fn_legal, fn_is_jr);

  // Next-state and decoded-class capture; the class only changes in DECODE.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = dec_class;
        alu_d   = fn_alu;
        if (dec_class == CL_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_RTYPE, CL_ADDI: state_d = ST_WB;
          CL_LW, CL_SW:      state_d = ST_MEM;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (class_q == CL_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= state_e'(RESET_STATE);
      class_q   <= CL_NONE;
      alu_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
    end
  end

  // Control word: a function of state and the captured class, zeroed during reset.
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      ST_FETCH: ctrl_c.ir_we = 1'b1;
      ST_EXEC: begin
        case (class_q)
          CL_RTYPE: ctrl_c.alu_ctrl = alu_q;
          CL_ADDI, CL_LW, CL_SW: begin
            ctrl_c.alu_ctrl  = ALU_ADD;
            ctrl_c.sel_alu_b = 1'b1;
          end
          CL_BEQ: begin
            ctrl_c.alu_ctrl = ALU_SUB;
            ctrl_c.pc_we    = 1'b1;
            ctrl_c.sel_pc   = zero ? SEL_PC_BRANCH : SEL_PC_PLUS4;
          end
          CL_J: begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.sel_pc = SEL_PC_JUMP;
          end
          CL_JAL: begin
            ctrl_c.pc_we      = 1'b1;
            ctrl_c.sel_pc     = SEL_PC_JUMP;
            ctrl_c.rf_we      = 1'b1;
            ctrl_c.sel_wa     = SEL_WA_R31;
            ctrl_c.sel_result = SEL_RES_PC4;
          end
          CL_JR: begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.sel_pc = SEL_PC_RS;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Address path held for the whole access so the address cannot drift.
        ctrl_c.alu_ctrl  = ALU_ADD;
        ctrl_c.sel_alu_b = 1'b1;
        if (class_q == CL_LW) begin
          ctrl_c.dmem_re = 1'b1;
        end else if (class_q == CL_SW) begin
          ctrl_c.dmem_we = 1'b1;
          if (mem_ready) begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.sel_pc = SEL_PC_PLUS4;
          end
        end
      end
      ST_WB: begin
        ctrl_c.rf_we  = 1'b1;
        ctrl_c.pc_we  = 1'b1;
        ctrl_c.sel_pc = SEL_PC_PLUS4;
        case (class_q)
          CL_RTYPE: begin
            ctrl_c.sel_wa     = SEL_WA_RD;
            ctrl_c.sel_result = SEL_RES_ALU;
            ctrl_c.alu_ctrl   = alu_q;
          end
          CL_ADDI: begin
            ctrl_c.sel_wa     = SEL_WA_RT;
            ctrl_c.sel_result = SEL_RES_ALU;
            ctrl_c.alu_ctrl   = ALU_ADD;
          end
          CL_LW: begin
            ctrl_c.sel_wa     = SEL_WA_RT;
            ctrl_c.sel_result = SEL_RES_DMEM;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (reset) ctrl_c = '0;
  end

  assign ir_we      = ctrl_c.ir_we;
  assign pc_we      = ctrl_c.pc_we;
  assign rf_we      = ctrl_c.rf_we;
  assign sel_wa     = ctrl_c.sel_wa;
  assign sel_alu_b  = ctrl_c.sel_alu_b;
  assign sel_result = ctrl_c.sel_result;
  assign sel_pc     = ctrl_c.sel_pc;
  assign alu_ctrl   = ctrl_c.alu_ctrl;
  assign dmem_re    = ctrl_c.dmem_re;
  assign dmem_we    = ctrl_c.dmem_we;
  assign illegal    = illegal_q;
  assign state      = state_q;

`ifdef MC_CONTROL_PERF_COUNTERS_EN
  logic [COUNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [COUNT_W-1:0] instret_count_q, instret_count_d;

  // Free-running counters; natural 32-bit wrap.
  always_comb begin
    cycle_count_d   = cycle_count_q + COUNT_W'(1);
    instret_count_d = instret_count_q + COUNT_W'(ctrl_c.pc_we);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_q   <= '0;
      instret_count_q <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver queues the expected control
// word per cycle, a negedge monitor pops and compares it against the DUT.
module tb_mc_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        ir_we, pc_we, rf_we, sel_alu_b, dmem_re, dmem_we, illegal;
  logic [1:0]  sel_wa, sel_result, sel_pc;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pc, rf;
    logic [1:0] wa;
    logic       alub;
    logic [1:0] res;
    logic [1:0] spc;
    logic [3:0] alu;
    logic       re, we, ill;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  mc_control_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .rf_we         (rf_we),
    .sel_wa        (sel_wa),
    .sel_alu_b     (sel_alu_b),
    .sel_result    (sel_result),
    .sel_pc        (sel_pc),
    .alu_ctrl      (alu_ctrl),
    .dmem_re       (dmem_re),
    .dmem_we       (dmem_we),
    .illegal       (illegal),
    .state         (state),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );

  always #5 clock = ~clock;

  function automatic obs_t mk(input int st, input int ir, input int pc, input int rf,
                              input int wa, input int alub, input int res, input int spc,
                              input int alu, input int re, input int we, input int ill);
    obs_t o;
    o.st = 3'(st); o.ir = 1'(ir); o.pc = 1'(pc); o.rf = 1'(rf);
    o.wa = 2'(wa); o.alub = 1'(alub); o.res = 2'(res); o.spc = 2'(spc);
    o.alu = 4'(alu); o.re = 1'(re); o.we = 1'(we); o.ill = 1'(ill);
    return o;
  endfunction

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clock) begin
    obs_t e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.st = state; a.ir = ir_we; a.pc = pc_we; a.rf = rf_we;
      a.wa = sel_wa; a.alub = sel_alu_b; a.res = sel_result; a.spc = sel_pc;
      a.alu = alu_ctrl; a.re = dmem_re; a.we = dmem_we; a.ill = illegal;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d ir=%b pc=%b rf=%b wa=%0d b=%b res=%0d spc=%0d alu=%b re=%b we=%b ill=%b, want st=%0d ir=%b pc=%b rf=%b wa=%0d b=%b res=%0d spc=%0d alu=%b re=%b we=%b ill=%b",
                 t, a.st, a.ir, a.pc, a.rf, a.wa, a.alub, a.res, a.spc, a.alu, a.re, a.we, a.ill,
                 e.st, e.ir, e.pc, e.rf, e.wa, e.alub, e.res, e.spc, e.alu, e.re, e.we, e.ill);
      end
    end
  end

  // One clock: drive inputs for the cycle just begun and queue its expected outputs.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic mr, input obs_t e);
    @(posedge clock);
    #1;
    reset = rst; opcode = op; funct = fn; zero = z; mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  obs_t FETCH, DECODE;

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    FETCH  = mk(0, 1,0,0,0,0,0,0,0,0,0,0);
    DECODE = mk(1, 0,0,0,0,0,0,0,0,0,0,0);

    // LW with immediate mem_ready
    cyc("rst_a",      1, 6'h23, 6'h00, 0, 1, mk(0, 0,0,0,0,0,0,0,0,0,0,0));
    cyc("rst_b",      1, 6'h23, 6'h00, 0, 1, mk(0, 0,0,0,0,0,0,0,0,0,0,0));
    cyc("lw_fetch",   0, 6'h23, 6'h00, 0, 1, FETCH);
    cyc("lw_decode",  0, 6'h23, 6'h00, 0, 1, DECODE);
    cyc("lw_exec",    0, 6'h23, 6'h00, 0, 1, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    cyc("lw_mem",     0, 6'h23, 6'h00, 0, 1, mk(3, 0,0,0,0,1,0,0,2,1,0,0));
    cyc("lw_wb",      0, 6'h23, 6'h00, 0, 1, mk(4, 0,1,1,0,0,1,0,0,0,0,0));

    // SW stalled three cycles
    cyc("sw_fetch",   0, 6'h2B, 6'h00, 0, 0, FETCH);
    cyc("sw_decode",  0, 6'h2B, 6'h00, 0, 0, DECODE);
    cyc("sw_exec",    0, 6'h2B, 6'h00, 0, 0, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    for (int i = 0; i < 3; i++)
      cyc("sw_mem_wait", 0, 6'h2B, 6'h00, 0, 0, mk(3, 0,0,0,0,1,0,0,2,0,1,0));
    cyc("sw_mem_done", 0, 6'h2B, 6'h00, 0, 1, mk(3, 0,1,0,0,1,0,0,2,0,1,0));

    // BEQ taken then not taken
    cyc("beq1_fetch", 0, 6'h04, 6'h00, 1, 0, FETCH);
    cyc("beq1_decode",0, 6'h04, 6'h00, 1, 0, DECODE);
    cyc("beq1_exec",  0, 6'h04, 6'h00, 1, 0, mk(2, 0,1,0,0,0,0,1,6,0,0,0));
    cyc("beq0_fetch", 0, 6'h04, 6'h00, 0, 0, FETCH);
    cyc("beq0_decode",0, 6'h04, 6'h00, 0, 0, DECODE);
    cyc("beq0_exec",  0, 6'h04, 6'h00, 0, 0, mk(2, 0,1,0,0,0,0,0,6,0,0,0));

    // SLT with stray mem_ready, then JAL
    cyc("slt_fetch",  0, 6'h00, 6'h2A, 0, 1, FETCH);
    cyc("slt_decode", 0, 6'h00, 6'h2A, 0, 1, DECODE);
    cyc("slt_exec",   0, 6'h00, 6'h2A, 0, 1, mk(2, 0,0,0,0,0,0,0,7,0,0,0));
    cyc("slt_wb",     0, 6'h00, 6'h2A, 0, 1, mk(4, 0,1,1,1,0,0,0,7,0,0,0));
    cyc("jal_fetch",  0, 6'h03, 6'h00, 0, 0, FETCH);
    cyc("jal_decode", 0, 6'h03, 6'h00, 0, 0, DECODE);
    cyc("jal_exec",   0, 6'h03, 6'h00, 0, 0, mk(2, 0,1,1,2,0,2,2,0,0,0,0));

    // SUB, ADDI, J, JR
    cyc("sub_fetch",  0, 6'h00, 6'h22, 0, 0, FETCH);
    cyc("sub_decode", 0, 6'h00, 6'h22, 0, 0, DECODE);
    cyc("sub_exec",   0, 6'h00, 6'h22, 0, 0, mk(2, 0,0,0,0,0,0,0,6,0,0,0));
    cyc("sub_wb",     0, 6'h00, 6'h22, 0, 0, mk(4, 0,1,1,1,0,0,0,6,0,0,0));
    cyc("addi_fetch", 0, 6'h08, 6'h00, 0, 0, FETCH);
    cyc("addi_decode",0, 6'h08, 6'h00, 0, 0, DECODE);
    cyc("addi_exec",  0, 6'h08, 6'h00, 0, 0, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    cyc("addi_wb",    0, 6'h08, 6'h00, 0, 0, mk(4, 0,1,1,0,0,0,0,2,0,0,0));
    cyc("j_fetch",    0, 6'h02, 6'h00, 0, 0, FETCH);
    cyc("j_decode",   0, 6'h02, 6'h00, 0, 0, DECODE);
    cyc("j_exec",     0, 6'h02, 6'h00, 0, 0, mk(2, 0,1,0,0,0,0,2,0,0,0,0));
    cyc("jr_fetch",   0, 6'h00, 6'h08, 0, 0, FETCH);
    cyc("jr_decode",  0, 6'h00, 6'h08, 0, 0, DECODE);
    cyc("jr_exec",    0, 6'h00, 6'h08, 0, 0, mk(2, 0,1,0,0,0,0,3,0,0,0,0));

    // Reset in the middle of a stalled LW: request drops, no commit
    cyc("lwr_fetch",  0, 6'h23, 6'h00, 0, 0, FETCH);
    cyc("lwr_decode", 0, 6'h23, 6'h00, 0, 0, DECODE);
    cyc("lwr_exec",   0, 6'h23, 6'h00, 0, 0, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    cyc("lwr_mem",    0, 6'h23, 6'h00, 0, 0, mk(3, 0,0,0,0,1,0,0,2,1,0,0));
    cyc("lwr_reset",  1, 6'h23, 6'h00, 0, 1, mk(3, 0,0,0,0,0,0,0,0,0,0,0));
    cyc("lwr_after",  0, 6'h3F, 6'h00, 0, 0, FETCH);

    // Undefined opcode traps until reset
    cyc("trap_decode",0, 6'h3F, 6'h00, 0, 1, DECODE);
    for (int i = 0; i < 20; i++)
      cyc("trap_hold", 0, 6'h3F, 6'h00, 1, 1, mk(7, 0,0,0,0,0,0,0,0,0,0,1));
    cyc("trap_reset", 1, 6'h3F, 6'h00, 0, 0, mk(7, 0,0,0,0,0,0,0,0,0,0,1));
    cyc("trap_clear", 0, 6'h00, 6'h00, 0, 0, FETCH);

    // Undefined R-type funct also traps
    cyc("badfn_decode",0, 6'h00, 6'h00, 0, 0, DECODE);
    cyc("badfn_trap", 0, 6'h00, 6'h00, 0, 0, mk(7, 0,0,0,0,0,0,0,0,0,0,1));
    cyc("badfn_reset",1, 6'h00, 6'h00, 0, 0, mk(7, 0,0,0,0,0,0,0,0,0,0,1));

`ifdef MC_CONTROL_PERF_COUNTERS_EN
    // ADDI + J + LW = 12 cycles, 3 retired
    cyc("pc_addi_f",  0, 6'h08, 6'h00, 0, 1, FETCH);
    cyc("pc_addi_d",  0, 6'h08, 6'h00, 0, 1, DECODE);
    cyc("pc_addi_e",  0, 6'h08, 6'h00, 0, 1, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    cyc("pc_addi_w",  0, 6'h08, 6'h00, 0, 1, mk(4, 0,1,1,0,0,0,0,2,0,0,0));
    cyc("pc_j_f",     0, 6'h02, 6'h00, 0, 1, FETCH);
    cyc("pc_j_d",     0, 6'h02, 6'h00, 0, 1, DECODE);
    cyc("pc_j_e",     0, 6'h02, 6'h00, 0, 1, mk(2, 0,1,0,0,0,0,2,0,0,0,0));
    cyc("pc_lw_f",    0, 6'h23, 6'h00, 0, 1, FETCH);
    cyc("pc_lw_d",    0, 6'h23, 6'h00, 0, 1, DECODE);
    cyc("pc_lw_e",    0, 6'h23, 6'h00, 0, 1, mk(2, 0,0,0,0,1,0,0,2,0,0,0));
    cyc("pc_lw_m",    0, 6'h23, 6'h00, 0, 1, mk(3, 0,0,0,0,1,0,0,2,1,0,0));
    cyc("pc_lw_w",    0, 6'h23, 6'h00, 0, 1, mk(4, 0,1,1,0,0,1,0,0,0,0,0));
    cyc("pc_next_f",  0, 6'h02, 6'h00, 0, 0, FETCH);
    check32("cycle_count_12", cycle_count, 32'd12);
    check32("instret_count_3", instret_count, 32'd3);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    @(posedge clock);
    #1;
    check32("cycle_count_wrap", cycle_count, 32'h0000_0000);
`else
    cyc("nc_fetch",   0, 6'h08, 6'h00, 0, 0, FETCH);
    cyc("nc_decode",  0, 6'h08, 6'h00, 0, 0, DECODE);
    check32("cycle_count_tied", cycle_count, 32'h0);
    check32("instret_count_tied", instret_count, 32'h0);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
